// File: rtl/addf_pipe.sv
// Pipelined WIDTH-bit add/subtract unit with carry-in, signed-overflow flag and
// valid/ready handshake; the carry chain is cut into STAGES registered slices.
module addf_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CI,
  input  logic             SUB,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] S,
  output logic             CO,
  output logic             OV
);

  localparam int W = WIDTH / STAGES;
  localparam int L = STAGES - 1;

  generate
    if (WIDTH < 1 || STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_params
      $error("addf_pipe: illegal WIDTH/STAGES combination");
    end
  endgenerate

  logic [STAGES-1:0] v_r;
  logic [STAGES-1:0] c_r;
  logic [WIDTH-1:0]  a_r    [STAGES];
  logic [WIDTH-1:0]  beff_r [STAGES];
  logic [WIDTH-1:0]  sum_r  [STAGES];
  logic              ov_r;

  logic [STAGES-1:0] ld_s;
  logic [STAGES-1:0] in_v_s;
  logic [STAGES-1:0] in_c_s;
  logic [STAGES-1:0] nxt_c_s;
  logic [WIDTH-1:0]  in_a_s    [STAGES];
  logic [WIDTH-1:0]  in_b_s    [STAGES];
  logic [WIDTH-1:0]  in_sum_s  [STAGES];
  logic [WIDTH-1:0]  nxt_sum_s [STAGES];
  logic [W:0]        slice_s   [STAGES];
  logic              ov_s;

  // Stage inputs, per-slice adders and the load chain
  always_comb begin
    in_v_s      = '0;
    in_c_s      = '0;
    nxt_c_s     = '0;
    ld_s        = '0;
    in_v_s[0]   = IN_VALID;
    in_c_s[0]   = CI ^ SUB;
    in_a_s[0]   = A;
    in_b_s[0]   = B ^ {WIDTH{SUB}};
    in_sum_s[0] = '0;
    for (int k = 1; k < STAGES; k++) begin
      in_v_s[k]   = v_r[k-1];
      in_c_s[k]   = c_r[k-1];
      in_a_s[k]   = a_r[k-1];
      in_b_s[k]   = beff_r[k-1];
      in_sum_s[k] = sum_r[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      // stage k loads when the consumer takes data or any stage at or after k has a hole
      ld_s[k] = OUT_READY | ~(&(v_r | ((STAGES'(1) << k) - STAGES'(1))));
      slice_s[k] = {1'b0, in_a_s[k][k*W +: W]} + {1'b0, in_b_s[k][k*W +: W]}
                 + {{W{1'b0}}, in_c_s[k]};
      nxt_sum_s[k]            = in_sum_s[k];
      nxt_sum_s[k][k*W +: W]  = slice_s[k][W-1:0];
      nxt_c_s[k]              = slice_s[k][W];
    end
  end

  assign ov_s = (in_a_s[L][WIDTH-1] == in_b_s[L][WIDTH-1]) &&
                (nxt_sum_s[L][WIDTH-1] != in_a_s[L][WIDTH-1]);

  // Pipeline registers; data only captured when the incoming slot is valid
  always_ff @(posedge CLK) begin
    if (RST) begin
      v_r  <= '0;
      c_r  <= '0;
      ov_r <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        a_r[k]    <= '0;
        beff_r[k] <= '0;
        sum_r[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (ld_s[k]) begin
          v_r[k] <= in_v_s[k];
          if (in_v_s[k]) begin
            a_r[k]    <= in_a_s[k];
            beff_r[k] <= in_b_s[k];
            sum_r[k]  <= nxt_sum_s[k];
            c_r[k]    <= nxt_c_s[k];
          end
        end
      end
      if (ld_s[L] && in_v_s[L]) begin
        ov_r <= ov_s;
      end
    end
  end

  assign IN_READY  = ld_s[0];
  assign OUT_VALID = v_r[L];
  assign S         = sum_r[L];
  assign CO        = c_r[L];
  assign OV        = ov_r;

endmodule

// File: tb/tb_addf_pipe.sv
// Scoreboard bench for addf_pipe: directed arithmetic, handshake and reset steps on
// STAGES=2, then random sweeps over STAGES in {2,1,4,8} at WIDTH=8.
module tb_addf_pipe;

  typedef struct packed {
    logic [7:0]  s;
    logic        co;
    logic        ov;
    logic [31:0] t;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        ci;
  logic        sub;
  int          sel;
  logic [3:0]  vin;
  logic [3:0]  in_ready;
  logic [3:0]  out_valid;
  logic [3:0]  co;
  logic [3:0]  ov;
  logic [7:0]  s_o [4];

  int          n_chk = 0;
  int          n_pass = 0;
  logic [31:0] cyc = 32'd0;
  logic        chk_lat;
  exp_t        sbq[$];
  logic [7:0]  last_s [4];
  logic [3:0]  last_co;
  logic [3:0]  last_ov;

  logic        acc;
  logic        ofire;
  logic [7:0]  obs_s;
  logic        obs_co;
  logic        obs_ov;
  int          n_out;
  logic [31:0] first_fire;
  logic [31:0] last_fire;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 32'd1;

  generate
    for (genvar g = 0; g < 4; g++) begin : g_dut
      assign vin[g] = in_valid && (sel == g);
      addf_pipe #(.WIDTH(8), .STAGES((g == 0) ? 2 : (g == 1) ? 1 : (g == 2) ? 4 : 8)) dut (
        .CLK(clk), .RST(rst), .IN_VALID(vin[g]), .IN_READY(in_ready[g]),
        .A(a), .B(b), .CI(ci), .SUB(sub),
        .OUT_VALID(out_valid[g]), .OUT_READY(out_ready),
        .S(s_o[g]), .CO(co[g]), .OV(ov[g]));
    end
  endgenerate

  function automatic int st_of(input int i);
    return (i == 0) ? 2 : (i == 1) ? 1 : (i == 2) ? 4 : 8;
  endfunction

  function automatic exp_t model(input logic [7:0] aa, input logic [7:0] bb,
                                 input logic cc, input logic ss);
    logic [7:0] be;
    logic [8:0] sum;
    exp_t       e;
    be   = bb ^ {8{ss}};
    sum  = {1'b0, aa} + {1'b0, be} + {8'd0, cc ^ ss};
    e.s  = sum[7:0];
    e.co = sum[8];
    e.ov = (aa[7] == be[7]) && (sum[7] != aa[7]);
    e.t  = 32'd0;
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
  endtask

  // Scoreboard monitor: outputs and handshakes are sampled on the falling edge
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      sbq.delete();
      for (int i = 0; i < 4; i++) last_s[i] = 8'd0;
      last_co = 4'd0;
      last_ov = 4'd0;
    end else begin
      if (out_valid[sel]) begin
        if (out_ready) begin
          check("unexpected_out", {31'd0, sbq.size() != 0}, 32'd1);
          if (sbq.size() != 0) begin
            e = sbq.pop_front();
            check("sb_S", {24'd0, s_o[sel]}, {24'd0, e.s});
            check("sb_CO", {31'd0, co[sel]}, {31'd0, e.co});
            check("sb_OV", {31'd0, ov[sel]}, {31'd0, e.ov});
            if (chk_lat) check("sb_latency", cyc - e.t, st_of(sel));
          end
        end
        last_s[sel]  = s_o[sel];
        last_co[sel] = co[sel];
        last_ov[sel] = ov[sel];
      end else begin
        check("idle_S", {24'd0, s_o[sel]}, {24'd0, last_s[sel]});
        check("idle_CO_OV", {30'd0, co[sel], ov[sel]}, {30'd0, last_co[sel], last_ov[sel]});
      end
      if (in_valid && in_ready[sel]) begin
        e   = model(a, b, ci, sub);
        e.t = cyc;
        sbq.push_back(e);
      end
    end
  end

  task automatic step();
    @(negedge clk);
    acc    = !rst && in_valid && in_ready[sel];
    ofire  = !rst && out_valid[sel] && out_ready;
    obs_s  = s_o[sel];
    obs_co = co[sel];
    obs_ov = ov[sel];
    if (ofire) begin
      n_out++;
      if (n_out == 1) first_fire = cyc;
      last_fire = cyc;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] aa, input logic [7:0] bb, input logic cc, input logic ss);
    a = aa; b = bb; ci = cc; sub = ss; in_valid = 1'b1;
  endtask

  task automatic op_check(input logic [7:0] aa, input logic [7:0] bb, input logic cc,
                          input logic ss, input logic [7:0] es, input logic eco,
                          input logic eov, input string tag);
    int n;
    drive(aa, bb, cc, ss);
    step();
    check({tag, "_accept"}, {31'd0, acc}, 32'd1);
    in_valid = 1'b0;
    n = 0;
    do begin
      step();
      n++;
    end while (!ofire && n < 20);
    check({tag, "_latency"}, n, st_of(sel));
    check({tag, "_S"}, {24'd0, obs_s}, {24'd0, es});
    check({tag, "_CO"}, {31'd0, obs_co}, {31'd0, eco});
    check({tag, "_OV"}, {31'd0, obs_ov}, {31'd0, eov});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before the bench completed");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ba [4];
    logic [7:0] bb [4];
    int         idx;
    int         n;
    exp_t       e0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = 8'd0; b = 8'd0;
    ci = 1'b0; sub = 1'b0; sel = 0; chk_lat = 1'b1; n_out = 0;
    first_fire = 32'd0; last_fire = 32'd0;
    step();
    step();
    rst = 1'b0;
    check("rst_OUT_VALID", {31'd0, out_valid[0]}, 32'd0);
    check("rst_S", {24'd0, s_o[0]}, 32'd0);
    check("rst_CO_OV", {30'd0, co[0], ov[0]}, 32'd0);
    check("rst_IN_READY", {31'd0, in_ready[0]}, 32'd1);

    op_check(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, "signed_ovf");
    op_check(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, "carry");
    op_check(8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0, "carry_ci");
    op_check(8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0, "sub_borrow");
    op_check(8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, "sub_ovf");

    // four back-to-back operations
    n_out = 0;
    for (int i = 0; i < 4; i++) begin
      drive(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
      step();
      check("b2b_accept", {31'd0, acc}, 32'd1);
    end
    in_valid = 1'b0;
    n = 0;
    while (n_out < 4 && n < 20) begin
      step();
      n++;
    end
    check("b2b_count", n_out, 4);
    check("b2b_consecutive", last_fire - first_fire, 32'd3);

    // backpressure: fill both stages, then release
    chk_lat = 1'b0;
    out_ready = 1'b0;
    n_out = 0;
    for (int i = 0; i < 4; i++) begin
      ba[i] = 8'($urandom);
      bb[i] = 8'($urandom);
    end
    idx = 0;
    for (int i = 0; i < 4; i++) begin
      drive(ba[idx], bb[idx], 1'b0, 1'(i));
      drive(ba[idx], bb[idx], 1'b0, idx[0]);
      step();
      if (acc) idx++;
    end
    e0 = model(ba[0], bb[0], 1'b0, 1'b0);
    check("bp_accepted", idx, 2);
    check("bp_IN_READY_low", {31'd0, in_ready[0]}, 32'd0);
    check("bp_OUT_VALID", {31'd0, out_valid[0]}, 32'd1);
    check("bp_hold_S", {24'd0, obs_s}, {24'd0, e0.s});
    check("bp_hold_now_S", {24'd0, s_o[0]}, {24'd0, e0.s});
    check("bp_hold_CO_OV", {30'd0, co[0], ov[0]}, {30'd0, e0.co, e0.ov});
    out_ready = 1'b1;
    drive(ba[idx], bb[idx], 1'b0, idx[0]);
    step();
    check("bp_ready_same_cycle", {31'd0, acc}, 32'd1);
    if (acc) idx++;
    n = 0;
    while (idx < 4 && n < 20) begin
      drive(ba[idx], bb[idx], 1'b0, idx[0]);
      step();
      if (acc) idx++;
      n++;
    end
    in_valid = 1'b0;
    n = 0;
    while (sbq.size() != 0 && n < 20) begin
      step();
      n++;
    end
    check("bp_out_count", n_out, 4);
    check("bp_drained", sbq.size(), 0);
    chk_lat = 1'b1;

    // reset with two operations in flight
    drive(8'h11, 8'h22, 1'b0, 1'b0);
    step();
    drive(8'h33, 8'h44, 1'b1, 1'b0);
    step();
    rst = 1'b1;
    drive(8'h55, 8'h66, 1'b0, 1'b0);
    step();
    rst = 1'b0;
    in_valid = 1'b0;
    check("midrst_OUT_VALID", {31'd0, out_valid[0]}, 32'd0);
    check("midrst_S", {24'd0, s_o[0]}, 32'd0);
    check("midrst_CO_OV", {30'd0, co[0], ov[0]}, 32'd0);
    check("midrst_IN_READY", {31'd0, in_ready[0]}, 32'd1);
    n_out = 0;
    for (int i = 0; i < 6; i++) step();
    check("midrst_no_ghosts", n_out, 0);

    // random sweep per STAGES configuration
    for (int c = 0; c < 4; c++) begin
      sel = c;
      out_ready = 1'b1;
      for (int i = 0; i < 1000; i++) begin
        in_valid = ($urandom_range(0, 3) != 0);
        a   = 8'($urandom);
        b   = 8'($urandom);
        ci  = 1'($urandom);
        sub = 1'($urandom);
        step();
      end
      in_valid = 1'b0;
      n = 0;
      while (sbq.size() != 0 && n < 20) begin
        step();
        n++;
      end
      check("sweep_drained", sbq.size(), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/addf_pipe.md
Name: addf_pipe

Overview:
- Parametrised, pipelined successor to the single-bit full-adder cell: a WIDTH-bit add/subtract unit with carry-in.
- The carry chain is split into STAGES registered slices, with a valid/ready handshake on both sides.
- Sits between operand sources and consumers in the datapath. Sustains one operation per cycle at a fixed latency of STAGES cycles.
- Adds a subtract mode and a signed-overflow flag; the single-bit cell has neither.

Parameters:
- WIDTH, 8, operand/result width in bits; must be >= 1.
- STAGES, 2, number of pipeline slices; 1 <= STAGES <= WIDTH and WIDTH % STAGES == 0, otherwise elaboration error.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RST  input  1  synchronous reset, active-high.
- IN_VALID  input  1  operands presented.
- IN_READY  output  1  unit accepts operands this cycle.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- CI  input  1  carry-in (add) / borrow-in (sub).
- SUB  input  1  0 = A+B+CI; 1 = A-B-CI.
- OUT_VALID  output  1  result valid.
- OUT_READY  input  1  consumer accepts result.
- S  output  WIDTH  sum/difference, modulo 2^WIDTH.
- CO  output  1  carry-out (add); not-borrow (sub).
- OV  output  1  two's-complement signed overflow.

Behaviour:
- Arithmetic: Beff = B XOR {WIDTH{SUB}}; cin = CI XOR SUB; {CO,S} = A + Beff + cin.
- Signed overflow: OV = (A[MSB] == Beff[MSB]) && (S[MSB] != A[MSB]).
- Slicing: slice width W = WIDTH/STAGES.
  - Stage k adds bits [k*W +: W] using the carry registered by stage k-1 (stage 0 uses cin).
  - Upper, not-yet-added operand bits travel with the data, registered each stage.
  - Lower result bits are carried forward registered.
- Transfer rules:
  - Input transfer occurs when IN_VALID && IN_READY.
  - Output transfer occurs when OUT_VALID && OUT_READY.
- Stage occupancy: each stage has a valid bit v[k]. Stage k may load when !v[k] || (stage k+1 loads), with the last stage loading when !OUT_VALID || OUT_READY.
- IN_READY = stage-0 load condition. It is combinational from OUT_READY through the chain; no skid buffer.
- Stage update rules:
  - A stage that loads while its predecessor is invalid clears its v bit.
  - A stage that does not load holds all contents unchanged (stall).
- Output registers: S, CO, OV and OUT_VALID are registered outputs of the final stage.
  - Held stable while OUT_VALID && !OUT_READY.
  - Values when OUT_VALID=0 are don't-care for consumers, but the bench checks they equal the last valid result or reset value.
- Latency: result of an input accepted in cycle t appears with OUT_VALID=1 in cycle t+STAGES when not stalled.
- Throughput: 1 result/cycle with OUT_READY held high.
- Ordering: results emerge strictly in acceptance order; no reordering, no drops.
- Capacity: at most STAGES operations in flight.
  - With OUT_READY=0, IN_READY deasserts once all stages are full.
  - IN_READY reasserts in the same cycle OUT_READY rises (simultaneous accept and emit allowed).
- Reset: when RST=1 at a clock edge:
  - All v bits, OUT_VALID, S, CO and OV are cleared to 0.
  - In-flight operations are discarded.
  - IN_READY is 1 in the cycle after reset.
  - Inputs during the RST cycle are ignored.
  - Reset takes priority over any simultaneous transfer.
- STAGES == 1: a single registered full-width adder with latency 1; handshake rules unchanged.
- STAGES == WIDTH: a bit-serial-per-stage chain, i.e. one full-adder slice per stage.
- No X-propagation from unselected data: operand bits of invalid stages never affect valid outputs.

Test Plan (WIDTH=8, STAGES=2, OUT_READY=1 unless stated):
- Signed overflow: A=0x7F, B=0x01, CI=0, SUB=0 accepted at t -> at t+2 OUT_VALID=1, S=0x80, CO=0, OV=1.
- Unsigned carry: A=0xFF, B=0x01, CI=0, SUB=0 -> S=0x00, CO=1, OV=0. Same with CI=1 -> S=0x01, CO=1.
- Subtract with borrow: A=0x05, B=0x07, CI=0, SUB=1 -> S=0xFE, CO=0, OV=0. A=0x80, B=0x01, CI=0, SUB=1 -> S=0x7F, CO=1, OV=1.
- Back-to-back and backpressure:
  - 4 back-to-back ops: results on 4 consecutive cycles in order.
  - Then hold OUT_READY=0: IN_READY=0 after 2 more accepted, and S holds the first stalled result.
  - Raise OUT_READY: remaining results emerge in order, one per cycle.
- Reset mid-operation: assert RST for 1 cycle with 2 ops in flight -> next cycle OUT_VALID=0, S=0, CO=0, OV=0, IN_READY=1, and the discarded ops never appear.
- Parameter sweep: WIDTH=8 with STAGES in {1,4,8}, plus 1000 random ops per config against a reference model -> zero mismatches, and latency == STAGES.
